// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search that drives a magnitude comparator
// and recovers the comparator's hidden target value one bit per compare cycle.
module sar_search_ctrl #(
  parameter int BIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           cmp_lt,
  input  logic           cmp_gt,
  input  logic           cmp_eq,
  output logic [BIT-1:0] trial,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [BIT-1:0] result
);
  localparam int KW = (BIT > 1) ? $clog2(BIT) : 1;
  typedef enum logic [1:0] {IDLE, PROBE, CHECK} state_t;
  state_t         state;
  logic [KW-1:0]  k;
  logic [BIT-1:0] bit_k;
  logic [BIT-1:0] refined;
  logic           unused_lt;
  // lt and "no flag" both keep bit k, so refinement only needs gt; bit k-1 is bit_k>>1
  assign unused_lt = cmp_lt;
  assign bit_k     = BIT'(1) << k;
  assign refined   = (cmp_gt ? trial & ~bit_k : trial) | (bit_k >> 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            trial <= BIT'(1) << (BIT - 1);
            k     <= KW'(BIT - 1);
            found <= 1'b0;
            busy  <= 1'b1;
            state <= PROBE;
          end
        PROBE:
          if (cmp_eq) begin
            result <= trial;
            found  <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            trial  <= '0;
            state  <= IDLE;
          end else begin
            trial <= refined;
            k     <= k - 1'b1;
            state <= (k == '0) ? CHECK : PROBE;
          end
        CHECK: begin
          result <= trial;
          found  <= cmp_eq;
          done   <= 1'b1;
          busy   <= 1'b0;
          trial  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: randomized searches against an arithmetic model of the SAR
// trial sequence, latency and result, plus directed control and reset cases.
module tb_sar_search_ctrl;
  localparam int BIT  = 4;
  localparam int MASK = (1 << BIT) - 1;
  logic           clk;
  logic           rst_n;
  logic           start;
  logic           cmp_lt;
  logic           cmp_gt;
  logic           cmp_eq;
  logic [BIT-1:0] trial;
  logic           busy;
  logic           done;
  logic           found;
  logic [BIT-1:0] result;
  logic [BIT-1:0] target;
  logic           forced;
  int             vectors;
  int             errors;

  sar_search_ctrl #(.BIT(BIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
    .trial(trial), .busy(busy), .done(done), .found(found), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ideal comparator against target, or one stuck at lt to emulate an out-of-range target
  always_comb begin
    cmp_lt = forced || (trial < target);
    cmp_gt = !forced && (trial > target);
    cmp_eq = !forced && (trial == target);
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tz(input int v);
    for (int i = 0; i < BIT; i++) if (v[i]) return i;
    return BIT;
  endfunction

  // Starts at a negedge. If pre is set, start is already high for this cycle 0.
  // With chain set, returns at the done cycle with start raised for the next search.
  task automatic search(input int tgt, input bit frc, input bit glitch, input bit pre, input bit chain);
    int np, dc, ptgt, fin, k, exp_t, res_exp;
    bit to_check;
    target   = tgt[BIT-1:0];
    forced   = frc;
    to_check = frc || (tgt == 0);
    np       = to_check ? BIT : BIT - tz(tgt);
    dc       = to_check ? BIT + 2 : np + 1;
    ptgt     = frc ? MASK : tgt;
    fin      = frc ? MASK : 0;
    res_exp  = frc ? MASK : tgt;
    if (!pre) start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= dc; c++) begin
      start = glitch && (c == 2);
      if (c <= np) begin
        k     = BIT - c;
        exp_t = (((ptgt >> (k + 1)) << (k + 1)) | (1 << k)) & MASK;
        check("probe_trial", int'(trial), exp_t);
        check("probe_busy", int'(busy), 1);
        check("probe_done", int'(done), 0);
      end else if (c < dc) begin
        check("check_trial", int'(trial), fin);
        check("check_busy", int'(busy), 1);
        check("check_done", int'(done), 0);
      end else begin
        check("done", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("result", int'(result), res_exp);
        check("found", int'(found), frc ? 0 : 1);
      end
      if (c < dc) @(negedge clk);
    end
    start = 1'b0;
    if (chain) begin
      start = 1'b1;
      return;
    end
    @(negedge clk);
    check("idle_trial", int'(trial), 0);
    check("idle_done", int'(done), 0);
    check("hold_result", int'(result), res_exp);
    check("hold_found", int'(found), frc ? 0 : 1);
  endtask

  initial begin
    int tgt;
    bit frc, gl, ch, pre;
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    target  = '0;
    forced  = 1'b0;
    #12;
    check("rst_trial", int'(trial), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    search(5, 0, 0, 0, 0);
    search(8, 0, 0, 0, 0);
    search(0, 0, 0, 0, 0);
    search(15, 0, 0, 0, 0);
    search(3, 1, 0, 0, 0);
    search(9, 0, 1, 0, 1);
    search(6, 0, 0, 1, 0);
    // reset in the middle of a search for 5
    target = 4'd5;
    forced = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_trial", int'(trial), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_found", int'(found), 0);
    check("mid_rst_result", int'(result), 0);
    @(negedge clk);
    check("mid_rst_nodone", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_done", int'(done), 0);
    search(5, 0, 0, 0, 0);
    pre = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tgt = int'($urandom_range(0, MASK));
      frc = ($urandom_range(0, 4) == 0);
      gl  = ($urandom_range(0, 3) == 0);
      ch  = ($urandom_range(0, 2) == 0) && (i != 59);
      search(tgt, frc, gl, pre, ch);
      pre = ch;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
